// File: rtl/vector_dot_unit.sv
// vector_dot_unit: holds a VEC_LEN-entry coefficient vector and streams
// VEC_LEN samples through it to produce one unsigned dot product per pass.
//
// state | meaning
// IDLE  | waiting for cmd_load / cmd_run
// LOAD  | writing coef[idx] on each input transfer
// RUN   | accumulating in_data*coef[idx] on each input transfer
// DONE  | holding the formatted result until out_ready
module vector_dot_unit #(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 10,
  parameter int ACC_W   = 20,
  parameter int OUT_W   = 8,
  parameter bit SAT_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_load,
  input  logic              cmd_run,
  input  logic              cmd_abort,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              coef_loaded,
  output logic              busy
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int PROD_W = 2 * DATA_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [ACC_W-1:0] OUT_MAX  = ACC_W'((64'd1 << OUT_W) - 64'd1);

  logic [1:0]        state;
  logic [DATA_W-1:0] coef [VEC_LEN];
  logic [IDX_W-1:0]  idx;
  logic [ACC_W-1:0]  acc;

  logic              xfer;
  logic              last;
  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  sum;
  logic [OUT_W-1:0]  res_data;
  logic              res_sat;

  assign in_ready = (state == S_LOAD) || (state == S_RUN);
  assign busy     = (state != S_IDLE);
  assign xfer     = in_valid && in_ready;
  assign last     = (idx == IDX_LAST);

  // Full-width product and running sum for the current element; ACC_W is
  // sized so this addition can never wrap.
  always_comb begin
    prod = {{DATA_W{1'b0}}, in_data} * {{DATA_W{1'b0}}, coef[idx]};
    sum  = acc + {{(ACC_W-PROD_W){1'b0}}, prod};
  end

  // Result formatting: clamp to all ones when saturation is enabled,
  // otherwise keep the low OUT_W bits.
  always_comb begin
    res_data = sum[OUT_W-1:0];
    res_sat  = 1'b0;
    if (SAT_EN && (sum > OUT_MAX)) begin
      res_data = {OUT_W{1'b1}};
      res_sat  = 1'b1;
    end
  end

  // Control FSM, coefficient store, accumulator and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      acc         <= '0;
      coef_loaded <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_sat     <= 1'b0;
      for (int i = 0; i < VEC_LEN; i++) coef[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_load) begin
            state       <= S_LOAD;
            idx         <= '0;
            coef_loaded <= 1'b0;
          end else if (cmd_run && coef_loaded) begin
            state <= S_RUN;
            idx   <= '0;
            acc   <= '0;
          end
        end
        S_LOAD: begin
          // abort wins over a simultaneous transfer; partial coefficients
          // stay in place but coef_loaded remains low
          if (cmd_abort) begin
            state <= S_IDLE;
          end else if (xfer) begin
            coef[idx] <= in_data;
            if (last) begin
              idx         <= '0;
              coef_loaded <= 1'b1;
              state       <= S_IDLE;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        S_RUN: begin
          if (cmd_abort) begin
            state <= S_IDLE;
            acc   <= '0;
          end else if (xfer) begin
            acc <= sum;
            if (last) begin
              idx       <= '0;
              out_data  <= res_data;
              out_sat   <= res_sat;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end else begin
              idx <= idx + IDX_ONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_dot_unit.sv
// tb_vector_dot_unit: directed bench for vector_dot_unit. Two instances share
// all inputs, one saturating and one truncating; expected results are pushed
// to a scoreboard queue when the last sample is driven and popped when the
// result is taken.
module tb_vector_dot_unit;

  localparam int N = 10;

  logic       clk = 1'b0;
  logic       reset, cmd_load, cmd_run, cmd_abort, in_valid, out_ready;
  logic [7:0] in_data;

  logic       in_ready_a, out_sat_a, out_valid_a, coef_loaded_a, busy_a;
  logic [7:0] out_data_a;
  logic       in_ready_b, out_sat_b, out_valid_b, coef_loaded_b, busy_b;
  logic [7:0] out_data_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] da;
    logic       sa;
    logic [7:0] db;
    logic       sb;
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] mcoef [N];
  logic [7:0] vec [N];

  always #5 clk = ~clk;

  vector_dot_unit #(.DATA_W(8), .VEC_LEN(N), .ACC_W(20), .OUT_W(8), .SAT_EN(1'b1)) dut_a (
    .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run),
    .cmd_abort(cmd_abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_a), .out_data(out_data_a), .out_sat(out_sat_a),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .coef_loaded(coef_loaded_a), .busy(busy_a)
  );

  vector_dot_unit #(.DATA_W(8), .VEC_LEN(N), .ACC_W(20), .OUT_W(8), .SAT_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .cmd_load(cmd_load), .cmd_run(cmd_run),
    .cmd_abort(cmd_abort), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_b), .out_data(out_data_b), .out_sat(out_sat_b),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .coef_loaded(coef_loaded_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic pulse_cmd(input logic ld, input logic rn);
    cmd_load = ld;
    cmd_run  = rn;
    tick();
    cmd_load = 1'b0;
    cmd_run  = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int w;
    w = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready_a && w < 50) begin
      tick();
      w++;
    end
    if (w == 50) chk("in_ready_timeout", {31'd0, in_ready_a}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic load_vec(input bit gap);
    pulse_cmd(1'b1, 1'b0);
    for (int i = 0; i < N; i++) begin
      send(vec[i]);
      mcoef[i] = vec[i];
      if (gap && i < N - 1) tick();
    end
  endtask

  task automatic run_vec(input bit gap);
    int unsigned s;
    exp_t e;
    s = 0;
    pulse_cmd(1'b0, 1'b1);
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) chk("out_valid_early", {31'd0, out_valid_a}, 32'd0);
      send(vec[i]);
      s += vec[i] * mcoef[i];
      if (gap && i < N - 1) tick();
    end
    chk("out_valid_latency", {31'd0, out_valid_a}, 32'd1);
    e.da = (s > 255) ? 8'hFF : s[7:0];
    e.sa = (s > 255);
    e.db = s[7:0];
    e.sb = 1'b0;
    sb_q.push_back(e);
  endtask

  task automatic take_result();
    int w;
    exp_t e;
    w = 0;
    while (!out_valid_a && w < 50) begin
      tick();
      w++;
    end
    chk("out_valid", {31'd0, out_valid_a}, 32'd1);
    if (sb_q.size() == 0) begin
      chk("scoreboard_empty", 32'(sb_q.size()), 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("out_data_sat", {24'd0, out_data_a}, {24'd0, e.da});
      chk("out_sat_sat", {31'd0, out_sat_a}, {31'd0, e.sa});
      chk("out_data_trunc", {24'd0, out_data_b}, {24'd0, e.db});
      chk("out_sat_trunc", {31'd0, out_sat_b}, {31'd0, e.sb});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_cleared", {31'd0, out_valid_a}, 32'd0);
    chk("idle_after_take", {31'd0, busy_a}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_load = 1'b0; cmd_run = 1'b0; cmd_abort = 1'b0;
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) mcoef[i] = 8'd0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    chk("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("rst_out_data", {24'd0, out_data_a}, 32'd0);
    chk("rst_out_sat", {31'd0, out_sat_a}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_a}, 32'd0);
    chk("rst_coef_loaded", {31'd0, coef_loaded_a}, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);

    // run without coefficients is ignored
    pulse_cmd(1'b0, 1'b1);
    chk("run_unloaded_busy", {31'd0, busy_a}, 32'd0);

    // basic load 1..10, samples 1 -> 55
    for (int i = 0; i < N; i++) vec[i] = 8'(i + 1);
    load_vec(1'b0);
    chk("coef_loaded", {31'd0, coef_loaded_a}, 32'd1);
    chk("load_done_busy", {31'd0, busy_a}, 32'd0);
    for (int i = 0; i < N; i++) vec[i] = 8'd1;
    run_vec(1'b0);
    take_result();

    // saturation vs truncation: 255*255*10 = 650250
    for (int i = 0; i < N; i++) vec[i] = 8'd255;
    load_vec(1'b0);
    run_vec(1'b0);
    take_result();

    // backpressure with cmd_run held during DONE
    for (int i = 0; i < N; i++) vec[i] = 8'(i + 1);
    load_vec(1'b0);
    for (int i = 0; i < N; i++) vec[i] = 8'd1;
    run_vec(1'b0);
    cmd_run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_out_data", {24'd0, out_data_a}, 32'd55);
      chk("bp_out_valid", {31'd0, out_valid_a}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready_a}, 32'd0);
    end
    cmd_run = 1'b0;
    take_result();
    for (int i = 0; i < N; i++) vec[i] = 8'd2;
    run_vec(1'b0);
    take_result();

    // in_valid gaps during load and run
    for (int i = 0; i < N; i++) vec[i] = 8'(i + 1);
    load_vec(1'b1);
    for (int i = 0; i < N; i++) vec[i] = 8'd1;
    run_vec(1'b1);
    take_result();

    // cmd_load and cmd_run together -> LOAD
    pulse_cmd(1'b1, 1'b1);
    chk("both_cmd_in_ready", {31'd0, in_ready_a}, 32'd1);
    chk("both_cmd_unloaded", {31'd0, coef_loaded_a}, 32'd0);
    for (int i = 0; i < N; i++) begin
      send(8'(i + 1));
      mcoef[i] = 8'(i + 1);
    end
    chk("both_cmd_loaded", {31'd0, coef_loaded_a}, 32'd1);

    // abort after 4 samples, with a transfer offered in the abort cycle
    pulse_cmd(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send(8'd1);
    cmd_abort = 1'b1; in_valid = 1'b1; in_data = 8'd99;
    tick();
    cmd_abort = 1'b0; in_valid = 1'b0;
    chk("abort_busy", {31'd0, busy_a}, 32'd0);
    tick();
    chk("abort_no_out", {31'd0, out_valid_a}, 32'd0);
    chk("abort_keeps_coef", {31'd0, coef_loaded_a}, 32'd1);
    for (int i = 0; i < N; i++) vec[i] = 8'd1;
    run_vec(1'b0);
    take_result();

    // reset mid-LOAD
    pulse_cmd(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) send(8'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_load_coef", {31'd0, coef_loaded_a}, 32'd0);
    chk("rst_mid_load_busy", {31'd0, busy_a}, 32'd0);
    pulse_cmd(1'b0, 1'b1);
    chk("rst_then_run_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_then_out_valid", {31'd0, out_valid_a}, 32'd0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
